muldiv_ctrl: RTL and testbench

- Sequencing controller for the EXE-stage multiply/divide resources.
- Accepts one MULT/MULTU/DIV/DIVU request from EXE and latches and sign/zero-extends the operands to 33 bits.
- Drives the pipelined multiplier IP, which has a fixed latency, and the handshaked divider IP.
- Captures the HI/LO results, raises done to the EXE stage, and handles pipeline flush (exception or eret) mid-operation, including draining a divide that is still in flight.

---
 rtl/muldiv_ctrl.sv | 143 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the EXE-stage multiply/divide units: latches and
// extends operands, times the fixed-latency multiplier, handshakes the divider.
module muldiv_ctrl #(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        is_div,
  input  logic        unsigned_op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        advance,
  input  logic        flush,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic [32:0] div_dividend,
  output logic [32:0] div_divisor,
  output logic        div_in_valid,
  input  logic [79:0] div_dout,
  input  logic        div_dout_valid,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result,
  output logic        hi_write,
  output logic        lo_write
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_ISSUE,
    S_DIV_WAIT,
    S_DIV_DRAIN,
    S_DONE
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [32:0] opa_q, opa_d;
  logic [32:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Product bits above 63 and the divider's padding fields carry no result.
  logic unused_bits;
  assign unused_bits = ^{mul_p[65:64], div_dout[79:72], div_dout[39:32]};

  function automatic logic [32:0] ext33(input logic [31:0] x, input logic is_unsigned);
    return {~is_unsigned & x[31], x};
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (req && !flush) begin
          opa_d   = ext33(op1, unsigned_op);
          opb_d   = ext33(op2, unsigned_op);
          cnt_d   = '0;
          state_d = is_div ? S_DIV_ISSUE : S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          hi_d    = mul_p[63:32];
          lo_d    = mul_p[31:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // The start pulse is already on the wire, so a flush must drain it.
      S_DIV_ISSUE: begin
        state_d = flush ? S_DIV_DRAIN : S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        if (flush) begin
          state_d = div_dout_valid ? S_IDLE : S_DIV_DRAIN;
        end else if (div_dout_valid) begin
          hi_d    = div_dout[31:0];
          lo_d    = div_dout[71:40];
          state_d = S_DONE;
        end
      end
      S_DIV_DRAIN: begin
        if (div_dout_valid) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (advance || flush) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mul_a        = opa_q;
  assign mul_b        = opb_q;
  assign div_dividend = opa_q;
  assign div_divisor  = opb_q;
  assign div_in_valid = (state_q == S_DIV_ISSUE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign hi_result    = hi_q;
  assign lo_result    = lo_q;
  assign hi_write     = done & ~flush;
  assign lo_write     = done & ~flush;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier and divider models.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        is_div;
  logic        unsigned_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        advance;
  logic        flush;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [65:0] mul_p;
  logic [32:0] div_dividend;
  logic [32:0] div_divisor;
  logic        div_in_valid;
  logic [79:0] div_dout;
  logic        div_dout_valid;
  logic        busy;
  logic        done;
  logic [31:0] hi_result;
  logic [31:0] lo_result;
  logic        hi_write;
  logic        lo_write;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req           (req),
    .is_div        (is_div),
    .unsigned_op   (unsigned_op),
    .op1           (op1),
    .op2           (op2),
    .advance       (advance),
    .flush         (flush),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_p         (mul_p),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_in_valid  (div_in_valid),
    .div_dout      (div_dout),
    .div_dout_valid(div_dout_valid),
    .busy          (busy),
    .done          (done),
    .hi_result     (hi_result),
    .lo_result     (lo_result),
    .hi_write      (hi_write),
    .lo_write      (lo_write)
  );

  // Multiplier model: product of the registered operands through MUL_LAT-1 stages.
  logic [65:0] mpipe [MUL_LAT-1];
  logic [65:0] prod;
  assign prod = $signed({{33{mul_a[32]}}, mul_a}) * $signed({{33{mul_b[32]}}, mul_b});
  always @(posedge clk) begin
    mpipe[0] <= prod;
    for (int i = 1; i < MUL_LAT - 1; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[MUL_LAT-2];

  // Divider model: result valid DIV_LAT cycles after the start pulse.
  logic [3:0]         dcnt = '0;
  logic [32:0]        dvd  = '0;
  logic [32:0]        dvs  = 33'd1;
  logic signed [32:0] dq;
  logic signed [32:0] dr;
  always_comb begin
    dq = '0;
    dr = '0;
    if (dvs != 33'd0) begin
      dq = $signed(dvd) / $signed(dvs);
      dr = $signed(dvd) % $signed(dvs);
    end
  end
  assign div_dout       = {8'h00, dq[31:0], 8'h00, dr[31:0]};
  assign div_dout_valid = (dcnt == 4'd1);
  always @(posedge clk) begin
    if (div_in_valid) begin
      dcnt <= 4'(DIV_LAT);
      dvd  <= div_dividend;
      dvs  <= div_divisor;
    end else if (dcnt != 4'd0) begin
      dcnt <= dcnt - 4'd1;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk33(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic d, input logic u,
                       input logic [31:0] a, input logic [31:0] b, input logic adv);
    req         = r;
    is_div      = d;
    unsigned_op = u;
    op1         = a;
    op2         = b;
    advance     = adv;
  endtask

  // Full multiply with advance=1: done expected exactly in cycle MUL_LAT+1.
  task automatic do_mul(input string t, input logic u, input logic [31:0] a,
                        input logic [31:0] b, input logic [32:0] ea,
                        input logic [31:0] eh, input logic [31:0] el);
    step(); drive(1'b1, 1'b0, u, a, b, 1'b1); #1;
    chk1({t, "_c0_busy"}, busy, 1'b0);
    step(); #1;
    chk1({t, "_c1_busy"}, busy, 1'b1);
    chk33({t, "_mul_a"}, mul_a, ea);
    for (int c = 2; c <= MUL_LAT; c++) begin
      step(); #1;
      chk1({t, "_early_done"}, done, 1'b0);
    end
    step(); #1;
    chk1({t, "_done"}, done, 1'b1);
    chk1({t, "_hi_write"}, hi_write, 1'b1);
    chk1({t, "_lo_write"}, lo_write, 1'b1);
    chk32({t, "_hi"}, hi_result, eh);
    chk32({t, "_lo"}, lo_result, el);
    step(); req = 1'b0; #1;
    chk1({t, "_after_done"}, done, 1'b0);
    chk1({t, "_after_busy"}, busy, 1'b0);
    chk1({t, "_after_hiw"}, hi_write, 1'b0);
    chk32({t, "_hi_held"}, hi_result, eh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_divv", div_in_valid, 1'b0);
    chk1("rst_hiw", hi_write, 1'b0);
    chk33("rst_mul_a", mul_a, 33'h0);
    chk33("rst_divisor", div_divisor, 33'h0);
    chk32("rst_hi", hi_result, 32'h0);
    chk32("rst_lo", lo_result, 32'h0);
    resetn = 1'b1;

    do_mul("mult", 1'b0, 32'hFFFF_FFFE, 32'h3, 33'h1_FFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_mul("multu", 1'b1, 32'hFFFF_FFFE, 32'h3, 33'h0_FFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFA);

    // req together with flush in IDLE: nothing latched
    step(); drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h1, 1'b1); flush = 1'b1; #1;
    step(); req = 1'b0; flush = 1'b0; #1;
    chk1("idleflush_busy", busy, 1'b0);
    chk33("idleflush_mul_a", mul_a, 33'h0_FFFF_FFFE);

    // flush in MUL_WAIT
    step(); drive(1'b1, 1'b0, 1'b1, 32'h5, 32'h5, 1'b1); #1;
    step(); #1;
    step(); req = 1'b0; flush = 1'b1; #1;
    chk1("mulflush_hiw", hi_write, 1'b0);
    step(); flush = 1'b0; #1;
    chk1("mulflush_busy", busy, 1'b0);
    chk32("mulflush_lo", lo_result, 32'hFFFF_FFFA);

    // DIV 100/7
    step(); drive(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, 1'b1); #1;
    chk1("div_c0_pulse", div_in_valid, 1'b0);
    step(); #1;
    chk1("div_c1_pulse", div_in_valid, 1'b1);
    chk33("div_dividend", div_dividend, 33'd100);
    chk33("div_divisor", div_divisor, 33'd7);
    for (int c = 2; c <= 9; c++) begin
      step(); #1;
      chk1("div_extra_pulse", div_in_valid, 1'b0);
      chk1("div_early_done", done, 1'b0);
    end
    step(); #1;
    chk1("div_done", done, 1'b1);
    chk1("div_hiw", hi_write, 1'b1);
    chk32("div_lo", lo_result, 32'd14);
    chk32("div_hi", hi_result, 32'd2);
    step(); req = 1'b0; #1;
    chk1("div_after_busy", busy, 1'b0);

    // Stall: DIV -100/7 with advance low for 3 cycles
    step(); drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 1'b0); #1;
    step(); #1;
    chk33("stall_dividend", div_dividend, 33'h1_FFFF_FF9C);
    for (int c = 2; c <= 9; c++) step();
    for (int c = 10; c <= 12; c++) begin
      step(); #1;
      chk1("stall_done", done, 1'b1);
      chk32("stall_hi", hi_result, 32'hFFFF_FFFE);
      chk32("stall_lo", lo_result, 32'hFFFF_FFF2);
    end
    step(); advance = 1'b1; #1;
    chk1("stall_adv_done", done, 1'b1);
    chk1("stall_adv_hiw", hi_write, 1'b1);
    step(); advance = 1'b0; #1;
    chk1("stall_idle_busy", busy, 1'b0);
    chk1("stall_idle_done", done, 1'b0);
    step(); req = 1'b0; #1;
    chk1("reaccept_busy", busy, 1'b1);
    chk1("reaccept_pulse", div_in_valid, 1'b1);

    // Flush in DIV_WAIT, new MULTU request held during the drain
    step(); flush = 1'b1; #1;
    chk1("drain_f_done", done, 1'b0);
    chk1("drain_f_hiw", hi_write, 1'b0);
    chk1("drain_f_pulse", div_in_valid, 1'b0);
    step(); flush = 1'b0; drive(1'b1, 1'b0, 1'b1, 32'd5, 32'd6, 1'b1); #1;
    chk1("drain_busy0", busy, 1'b1);
    for (int c = 18; c <= 23; c++) begin
      step(); flush = (c == 19); #1;
      chk1("drain_busy", busy, 1'b1);
      chk1("drain_done", done, 1'b0);
      chk1("drain_hiw", hi_write, 1'b0);
    end
    step(); flush = 1'b0; #1;
    chk1("drain_idle_busy", busy, 1'b0);
    chk32("drain_hi_kept", hi_result, 32'hFFFF_FFFE);
    chk32("drain_lo_kept", lo_result, 32'hFFFF_FFF2);
    chk33("drain_no_latch", mul_a, 33'h1_FFFF_FF9C);
    step(); #1;
    chk1("post_drain_busy", busy, 1'b1);
    chk33("post_drain_mul_a", mul_a, 33'h0_0000_0005);
    chk33("post_drain_mul_b", mul_b, 33'h0_0000_0006);
    for (int c = 2; c <= MUL_LAT; c++) step();
    step(); #1;
    chk1("post_drain_done", done, 1'b1);
    chk32("post_drain_hi", hi_result, 32'h0);
    chk32("post_drain_lo", lo_result, 32'h1E);
    step(); req = 1'b0; #1;

    // Flush in the same cycle as dout_valid: no capture
    step(); drive(1'b1, 1'b1, 1'b1, 32'd50, 32'd5, 1'b1); #1;
    step(); req = 1'b0; #1;
    for (int c = 2; c <= 8; c++) step();
    step(); flush = 1'b1; #1;
    chk1("coflush_done", done, 1'b0);
    chk1("coflush_hiw", hi_write, 1'b0);
    step(); flush = 1'b0; #1;
    chk1("coflush_busy", busy, 1'b0);
    chk32("coflush_lo", lo_result, 32'h1E);

    // Flush while in DONE suppresses the writes
    step(); drive(1'b1, 1'b0, 1'b1, 32'd2, 32'd3, 1'b0); #1;
    for (int c = 1; c <= MUL_LAT; c++) step();
    step(); flush = 1'b1; #1;
    chk1("doneflush_done", done, 1'b1);
    chk1("doneflush_hiw", hi_write, 1'b0);
    chk1("doneflush_low", lo_write, 1'b0);
    chk32("doneflush_lo", lo_result, 32'd6);
    step(); flush = 1'b0; req = 1'b0; #1;
    chk1("doneflush_busy", busy, 1'b0);

    // Async reset in MUL_WAIT with cnt=3
    step(); drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd9, 1'b1); #1;
    for (int c = 1; c <= 4; c++) step();
    resetn = 1'b0; req = 1'b0; #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk33("arst_mul_a", mul_a, 33'h0);
    chk33("arst_mul_b", mul_b, 33'h0);
    chk32("arst_hi", hi_result, 32'h0);
    chk32("arst_lo", lo_result, 32'h0);
    step(); resetn = 1'b1;
    do_mul("arst_mult", 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 33'h1_FFFF_FFFD, 32'h0, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
